// File: rtl/parking_hour_logger.sv
// parking_hour_logger
// Counts car entries per simulated hour, commits each hour's count to an
// external HOURSxDATA_W RAM, then scans the RAM back for display once the
// last hour of the day has been written.
//
// Optional feature macro: PARKING_HOUR_LOGGER_PEAK_EN
//   defined   : tracks the hour with the highest committed count
//   undefined : peak_hour / peak_count are tied to zero
//
// state  | meaning
// -------+-------------------------------------------------------------
// LOG    | counting car_enter pulses for cur_hour
// COMMIT | one-cycle RAM write of the finished hour's count
// SCAN   | day complete; cycle RAM read port, present hour/count pairs

module parking_hour_logger #(
  parameter int HOURS    = 8,
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 4,
  parameter int SCAN_DIV = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              car_enter,
  input  logic              next_hour,
  output logic              wren,
  output logic [ADDR_W-1:0] wraddress,
  output logic [DATA_W-1:0] data,
  output logic [ADDR_W-1:0] rdaddress,
  input  logic [DATA_W-1:0] q,
  output logic [ADDR_W-1:0] cur_hour,
  output logic              day_done,
  output logic              scan_valid,
  output logic [ADDR_W-1:0] scan_hour,
  output logic [DATA_W-1:0] scan_count,
  output logic [ADDR_W-1:0] peak_hour,
  output logic [DATA_W-1:0] peak_count
);

  localparam logic [DATA_W-1:0] CNT_MAX   = '1;
  localparam logic [ADDR_W-1:0] LAST_HOUR = ADDR_W'(HOURS - 1);
  localparam int                DIV_W     = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LOAD  = DIV_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    LOG    = 2'd0,
    COMMIT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] count;
  logic [DATA_W-1:0] count_inc;
  logic [DIV_W-1:0]  div;

  // Saturating increment of the running hour count.
  always_comb begin
    count_inc = (count == CNT_MAX) ? count : count + DATA_W'(1);
  end

  // Sequencer: counting, one-cycle commit, and the divided readout scan.
  // The scan divider is a down-counter; a pair is captured at terminal count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= LOG;
      count      <= '0;
      cur_hour   <= '0;
      wren       <= 1'b0;
      wraddress  <= '0;
      data       <= '0;
      rdaddress  <= '0;
      div        <= '0;
      day_done   <= 1'b0;
      scan_valid <= 1'b0;
      scan_hour  <= '0;
      scan_count <= '0;
    end else begin
      case (state)
        LOG: begin
          // An entry coincident with next_hour belongs to the ending hour.
          count <= car_enter ? count_inc : count;
          if (next_hour) begin
            state     <= COMMIT;
            wren      <= 1'b1;
            wraddress <= cur_hour;
            data      <= car_enter ? count_inc : count;
          end
        end
        COMMIT: begin
          wren  <= 1'b0;
          count <= car_enter ? DATA_W'(1) : '0;
          if (cur_hour == LAST_HOUR) begin
            state     <= SCAN;
            count     <= '0;
            rdaddress <= '0;
            div       <= DIV_LOAD;
            day_done  <= 1'b1;
          end else begin
            state    <= LOG;
            cur_hour <= cur_hour + ADDR_W'(1);
          end
        end
        SCAN: begin
          if (div == '0) begin
            scan_hour  <= rdaddress;
            scan_count <= q;
            scan_valid <= 1'b1;
            rdaddress  <= (rdaddress == LAST_HOUR) ? '0 : rdaddress + ADDR_W'(1);
            div        <= DIV_LOAD;
          end else begin
            div <= div - DIV_W'(1);
          end
        end
        default: state <= LOG;
      endcase
    end
  end

`ifdef PARKING_HOUR_LOGGER_PEAK_EN
  // Peak tracker: strictly greater wins, so ties keep the earlier hour.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      peak_hour  <= '0;
      peak_count <= '0;
    end else if (state == COMMIT && count > peak_count) begin
      peak_hour  <= cur_hour;
      peak_count <= count;
    end
  end
`else
  assign peak_hour  = '0;
  assign peak_count = '0;
`endif

endmodule
